udma_cfg_arbiter: RTL and testbench
===================================

Name: udma_cfg_arbiter

Overview:
Arbitrates N_MST configuration requesters onto the single APB port that feeds the uDMA configuration interface. Typical requesters are the SoC APB bridge, a debug path and an autonomous channel sequencer. The block grants requesters in round-robin order and sequences the APB SETUP/ACCESS phases. It returns read data or an error to the owning requester and aborts an access when PREADY stays low too long.

Parameters:
N_MST, 2, number of requesters (>=1)
APB_ADDR_WIDTH, 12, APB address width
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
clk_i  in  1  clock, all state on rising edge
rstn_i  in  1  asynchronous active-low reset
mst_req_i  in  N_MST  request; held until mst_gnt_o
mst_addr_i  in  N_MST x APB_ADDR_WIDTH  per-requester address
mst_wdata_i  in  N_MST x 32  per-requester write data
mst_we_i  in  N_MST  1=write, 0=read
mst_gnt_o  out  N_MST  one-hot, 1-cycle accept pulse
mst_rvalid_o  out  N_MST  one-hot, 1-cycle response pulse to owner
mst_rdata_o  out  32  read data, valid with mst_rvalid_o
mst_err_o  out  1  error flag, valid with mst_rvalid_o
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- One clock domain, clk_i. rstn_i is asynchronous and active-low.
- Reset values: state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; mst_gnt_o=0, mst_rvalid_o=0, mst_rdata_o=0, mst_err_o=0; round-robin pointer selects requester 0 first; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any mst_req_i is high, pick the winner round-robin, starting at (last_owner+1) mod N_MST.
  - mst_gnt_o[winner] is combinational and asserted in this cycle only.
  - Register addr, wdata, we and the owner index; go to SETUP.
  - With no request, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE from the captured values. Lasts exactly 1 cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; timeout counter increments each cycle.
  - On PREADY=1: register rdata = PWRITE ? 0 : PRDATA and err = PSLVERR; go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: register rdata=0 and err=1; go to RESP.
  - PREADY takes priority over timeout when both occur in the same cycle.
- RESP:
  - PSEL=0, PENABLE=0; mst_rvalid_o[owner]=1 for exactly one cycle.
  - last_owner updates to owner; counter clears; go to IDLE.
- APB outputs hold stable from SETUP through the end of ACCESS. PADDR/PWDATA/PWRITE keep their last value when idle.
- Latency:
  - Grant at cycle T; SETUP at T+1; ACCESS from T+2.
  - With PREADY at T+2+k, rvalid is at T+3+k.
  - Earliest next grant is at T+4+k, so back-to-back throughput is 1 transfer per 4 cycles minimum.
- Requests and grants:
  - A requester that keeps req high after its grant is a new request. It competes again in the next IDLE.
  - Requests arriving in non-IDLE states wait; they are not dropped.
  - N_MST=1: the pointer is a constant and requester 0 is always granted.
- Simultaneous requests: exactly one grant per IDLE cycle, and a continuously requesting master waits at most N_MST-1 transactions.
- Reset mid-operation (assertion of rstn_i):
  - Outputs return to reset values asynchronously and PSEL drops immediately.
  - The in-flight transaction is discarded with no rvalid issued.
  - The round-robin pointer resets.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter must not wrap before the timeout fires.

Decomposition:
- Package udma_cfg_arb_pkg:
  - cfg_arb_state_e enum (IDLE, SETUP, ACCESS, RESP).
  - Localparam helper for the counter width.
- Sub-module udma_cfg_rr_arb: combinational round-robin pick. Inputs are the req vector and the last_owner index; outputs are the one-hot grant and the winner index. It is instantiated once.
- The FSM, capture registers and timeout counter live in the top module.

Test Plan:
- Write, immediate ready: master0 write addr 0x084, data 0x1234_5678, PREADY=1 throughout -> gnt[0] at T; PSEL at T+1 with PWRITE=1 and PADDR=0x084; PENABLE at T+2; rvalid[0] at T+3 with err=0 and rdata=0.
- Read, wait states: master1 read addr 0x100; PREADY low for 3 ACCESS cycles, then high with PRDATA=0xCAFE_F00D -> rvalid[1] at T+6, rdata=0xCAFE_F00D, err=0; PSEL/PENABLE remain stable throughout.
- Round-robin fairness: N_MST=3, all reqs held high from reset -> grant order 0,1,2,0,1; grants spaced 4 cycles apart with PREADY=1; at most one grant per cycle.
- Timeout: TIMEOUT_CYCLES=16, PREADY held low -> after 16 ACCESS cycles, rvalid with err=1 and rdata=0; PSEL=0 on the next cycle; the next request is then served normally.
- Slave error, with tie-break: PREADY=1 and PSLVERR=1 on a read -> rvalid with err=1. Separately, PREADY arriving in the same cycle as timeout expiry -> completion wins and err=PSLVERR.
- Reset mid-ACCESS: assert rstn_i low while PENABLE=1 -> PSEL and PENABLE low without waiting for a clock edge; no rvalid; after release, a new request from master1 (with master0 also requesting) grants master0 first.

Source files
------------

// File: rtl/udma_cfg_arbiter_pkg.sv
// udma_cfg_arb_pkg: shared types and width helpers
// for the uDMA config APB arbiter.
package udma_cfg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } cfg_arb_state_e;

  // Timeout counter width, never below one bit.
  function automatic int cnt_width(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

  // Requester index width, never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/udma_cfg_arbiter_if.sv
// udma_cfg_arbiter_if: APB bus between the arbiter
// and the uDMA configuration slave.
interface udma_cfg_arbiter_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/udma_cfg_arbiter_rr_arb.sv
// udma_cfg_rr_arb: combinational round-robin pick,
// searching from last+1 and wrapping modulo N_MST.
module udma_cfg_rr_arb
  import udma_cfg_arb_pkg::*;
#(
  parameter int N_MST = 2
) (
  input  logic [N_MST-1:0]              req,
  input  logic [idx_width(N_MST)-1:0]   last,
  output logic [N_MST-1:0]              gnt,
  output logic [idx_width(N_MST)-1:0]   idx
);

  localparam int IW = idx_width(N_MST);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] NV = PW'(N_MST);

  logic          found;
  logic [PW-1:0] cand;

  // First requester at or after last+1 wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_MST; i++) begin
      cand = {1'b0, last} + PW'(1) + PW'(i);
      if (cand >= NV)
        cand = cand - NV;
      if (!found && req[cand[IW-1:0]]) begin
        found              = 1'b1;
        gnt[cand[IW-1:0]]  = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/udma_cfg_arbiter.sv
// udma_cfg_arbiter: round-robin arbiter of N_MST
// config requesters onto one APB port with timeout.
module udma_cfg_arbiter
  import udma_cfg_arb_pkg::*;
#(
  parameter int N_MST          = 2,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [N_MST-1:0]                      mst_req_i,
  input  logic [N_MST-1:0][APB_ADDR_WIDTH-1:0]  mst_addr_i,
  input  logic [N_MST-1:0][31:0]                mst_wdata_i,
  input  logic [N_MST-1:0]                      mst_we_i,
  output logic [N_MST-1:0]                      mst_gnt_o,
  output logic [N_MST-1:0]                      mst_rvalid_o,
  output logic [31:0]                           mst_rdata_o,
  output logic                                  mst_err_o,
  udma_cfg_arbiter_if.master                    apb
);

  localparam int IW = idx_width(N_MST);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(N_MST - 1);

  cfg_arb_state_e   state_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    win;
  logic [N_MST-1:0] arb_gnt;
  logic [CW-1:0]    cnt_q;
  logic             to_hit;

  udma_cfg_rr_arb #(
    .N_MST (N_MST)
  ) u_rr (
    .req  (mst_req_i),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (win)
  );

  // Grant is only offered while the port is idle.
  assign mst_gnt_o = (state_q == IDLE) ? arb_gnt : '0;

  // Abort point: last allowed ACCESS cycle.
  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  // Transfer FSM with capture regs and timeout counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_q       <= LAST_RST;
      cnt_q        <= '0;
      apb.PADDR    <= '0;
      apb.PWDATA   <= '0;
      apb.PWRITE   <= 1'b0;
      apb.PSEL     <= 1'b0;
      apb.PENABLE  <= 1'b0;
      mst_rvalid_o <= '0;
      mst_rdata_o  <= '0;
      mst_err_o    <= 1'b0;
    end else begin
      mst_rvalid_o <= '0;
      unique case (state_q)
        IDLE: begin
          if (|mst_req_i) begin
            owner_q    <= win;
            apb.PADDR  <= mst_addr_i[win];
            apb.PWDATA <= mst_wdata_i[win];
            apb.PWRITE <= mst_we_i[win];
            apb.PSEL   <= 1'b1;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            mst_rdata_o           <= apb.PWRITE ? '0 : apb.PRDATA;
            mst_err_o             <= apb.PSLVERR;
            mst_rvalid_o[owner_q] <= 1'b1;
            apb.PSEL              <= 1'b0;
            apb.PENABLE           <= 1'b0;
            state_q               <= RESP;
          end else if (to_hit) begin
            mst_rdata_o           <= '0;
            mst_err_o             <= 1'b1;
            mst_rvalid_o[owner_q] <= 1'b1;
            apb.PSEL              <= 1'b0;
            apb.PENABLE           <= 1'b0;
            state_q               <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          last_q  <= owner_q;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_cfg_arbiter.sv
// tb_udma_cfg_arbiter: directed checks of grant order,
// APB phasing, wait states, timeout and async reset.
module tb_udma_cfg_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int TO = 16;

  logic                   clk  = 1'b0;
  logic                   rstn = 1'b1;
  logic [N-1:0]           req;
  logic [N-1:0]           we;
  logic [N-1:0][AW-1:0]   addr;
  logic [N-1:0][31:0]     wdata;
  logic [N-1:0]           gnt;
  logic [N-1:0]           rvalid;
  logic [31:0]            rdata;
  logic                   err;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] order [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

  udma_cfg_arbiter_if #(.ADDR_WIDTH(AW)) apb ();

  udma_cfg_arbiter #(
    .N_MST          (N),
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .mst_req_i    (req),
    .mst_addr_i   (addr),
    .mst_wdata_i  (wdata),
    .mst_we_i     (we),
    .mst_gnt_o    (gnt),
    .mst_rvalid_o (rvalid),
    .mst_rdata_o  (rdata),
    .mst_err_o    (err),
    .apb          (apb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Zero-wait transfer on master m, checked phase by phase.
  task automatic txn(input int m,
                     input logic [AW-1:0] a,
                     input logic [31:0] d,
                     input logic w,
                     input logic [31:0] prd,
                     input logic slv,
                     input logic [31:0] exp_rd,
                     input logic exp_er,
                     input string tag);
    req[m]      = 1'b1;
    addr[m]     = a;
    wdata[m]    = d;
    we[m]       = w;
    apb.PREADY  = 1'b1;
    apb.PRDATA  = prd;
    apb.PSLVERR = slv;
    settle;
    chk({tag, ".gnt"}, 32'(gnt), 32'(1) << m);
    cyc;
    req[m] = 1'b0;
    settle;
    chk({tag, ".setup_psel"}, 32'(apb.PSEL), 32'd1);
    chk({tag, ".setup_pen"}, 32'(apb.PENABLE), 32'd0);
    chk({tag, ".pwrite"}, 32'(apb.PWRITE), 32'(w));
    chk({tag, ".paddr"}, 32'(apb.PADDR), 32'(a));
    chk({tag, ".pwdata"}, apb.PWDATA, d);
    cyc;
    settle;
    chk({tag, ".access_pen"}, 32'(apb.PENABLE), 32'd1);
    cyc;
    settle;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(1) << m);
    chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".err"}, 32'(err), 32'(exp_er));
    chk({tag, ".resp_psel"}, 32'(apb.PSEL), 32'd0);
    cyc;
  endtask

  initial begin
    req         = '0;
    we          = '0;
    addr        = '0;
    wdata       = '0;
    apb.PREADY  = 1'b1;
    apb.PRDATA  = '0;
    apb.PSLVERR = 1'b0;

    // Reset values
    #1 rstn = 1'b0;
    #2;
    chk("rst.psel", 32'(apb.PSEL), 32'd0);
    chk("rst.penable", 32'(apb.PENABLE), 32'd0);
    chk("rst.pwrite", 32'(apb.PWRITE), 32'd0);
    chk("rst.paddr", 32'(apb.PADDR), 32'd0);
    chk("rst.pwdata", apb.PWDATA, 32'd0);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc;

    // Round robin with all masters requesting
    addr[0]  = 12'h100;
    addr[1]  = 12'h200;
    addr[2]  = 12'h300;
    wdata[0] = 32'h0000_0A00;
    wdata[1] = 32'h0000_0A01;
    wdata[2] = 32'h0000_0A02;
    req      = '1;
    for (int c = 0; c < 20; c++) begin
      if (c == 17)
        req = '0;
      settle;
      chk("rr.gnt", 32'(gnt),
          (c % 4 == 0 && c <= 16) ? 32'(order[c / 4]) : 32'd0);
      chk("rr.rvalid", 32'(rvalid),
          (c % 4 == 3) ? 32'(order[c / 4]) : 32'd0);
      if (c % 4 == 1)
        chk("rr.paddr", 32'(apb.PADDR),
            (order[c / 4] == 3'b001) ? 32'h100 :
            (order[c / 4] == 3'b010) ? 32'h200 : 32'h300);
      cyc;
    end

    // Write, immediate ready; PRDATA must be ignored
    txn(0, 12'h084, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF,
        1'b0, 32'h0, 1'b0, "wr");

    // Read on master 1 with three wait states
    req[1]     = 1'b1;
    addr[1]    = 12'h100;
    we[1]      = 1'b0;
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h0;
    settle;
    chk("ws.gnt", 32'(gnt), 32'b010);
    cyc;
    req[1] = 1'b0;
    settle;
    chk("ws.setup_psel", 32'(apb.PSEL), 32'd1);
    chk("ws.setup_pen", 32'(apb.PENABLE), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc;
      settle;
      chk("ws.psel", 32'(apb.PSEL), 32'd1);
      chk("ws.pen", 32'(apb.PENABLE), 32'd1);
      chk("ws.paddr", 32'(apb.PADDR), 32'h100);
      chk("ws.norv", 32'(rvalid), 32'd0);
    end
    cyc;
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'hCAFE_F00D;
    settle;
    chk("ws.pen_last", 32'(apb.PENABLE), 32'd1);
    cyc;
    settle;
    chk("ws.rvalid", 32'(rvalid), 32'b010);
    chk("ws.rdata", rdata, 32'hCAFE_F00D);
    chk("ws.err", 32'(err), 32'd0);
    cyc;

    // Timeout on master 2 with PREADY stuck low
    req[2]     = 1'b1;
    addr[2]    = 12'h200;
    we[2]      = 1'b0;
    apb.PREADY = 1'b0;
    apb.PRDATA = 32'h1111_1111;
    settle;
    chk("to.gnt", 32'(gnt), 32'b100);
    cyc;
    req[2] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc;
      settle;
      chk("to.pen", 32'(apb.PENABLE), 32'd1);
      chk("to.norv", 32'(rvalid), 32'd0);
    end
    cyc;
    settle;
    chk("to.rvalid", 32'(rvalid), 32'b100);
    chk("to.err", 32'(err), 32'd1);
    chk("to.rdata", rdata, 32'd0);
    chk("to.psel", 32'(apb.PSEL), 32'd0);
    cyc;
    txn(0, 12'h0C0, 32'hA5A5_0001, 1'b1, 32'h0,
        1'b0, 32'h0, 1'b0, "post_to");

    // Slave error on a read
    txn(1, 12'h104, 32'h0, 1'b0, 32'hDEAD_BEEF,
        1'b1, 32'hDEAD_BEEF, 1'b1, "slverr");
    apb.PSLVERR = 1'b0;

    // PREADY in the timeout-expiry cycle wins
    req[2]     = 1'b1;
    addr[2]    = 12'h208;
    apb.PREADY = 1'b0;
    settle;
    chk("tie.gnt", 32'(gnt), 32'b100);
    cyc;
    req[2] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc;
      settle;
      chk("tie.norv", 32'(rvalid), 32'd0);
    end
    cyc;
    apb.PREADY  = 1'b1;
    apb.PRDATA  = 32'h5A5A_A5A5;
    apb.PSLVERR = 1'b0;
    settle;
    chk("tie.pen", 32'(apb.PENABLE), 32'd1);
    cyc;
    settle;
    chk("tie.rvalid", 32'(rvalid), 32'b100);
    chk("tie.err", 32'(err), 32'd0);
    chk("tie.rdata", rdata, 32'h5A5A_A5A5);
    cyc;
    txn(0, 12'h010, 32'h0000_00FF, 1'b1, 32'h0,
        1'b0, 32'h0, 1'b0, "pre_rst");

    // Reset in the middle of an ACCESS phase
    req[1]     = 1'b1;
    addr[1]    = 12'h120;
    we[1]      = 1'b0;
    apb.PREADY = 1'b0;
    settle;
    chk("mr.gnt", 32'(gnt), 32'b010);
    cyc;
    req[1] = 1'b0;
    cyc;
    settle;
    chk("mr.pen_before", 32'(apb.PENABLE), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mr.psel_async", 32'(apb.PSEL), 32'd0);
    chk("mr.pen_async", 32'(apb.PENABLE), 32'd0);
    chk("mr.paddr_async", 32'(apb.PADDR), 32'd0);
    cyc;
    settle;
    chk("mr.norv", 32'(rvalid), 32'd0);
    @(negedge clk);
    rstn       = 1'b1;
    apb.PREADY = 1'b1;
    apb.PRDATA = 32'h0BAD_F00D;
    cyc;
    req[0]  = 1'b1;
    req[1]  = 1'b1;
    addr[0] = 12'h0F0;
    we[0]   = 1'b0;
    settle;
    chk("mr.norv_after", 32'(rvalid), 32'd0);
    chk("mr.gnt_first", 32'(gnt), 32'b001);
    cyc;
    req[0] = 1'b0;
    settle;
    chk("mr.paddr", 32'(apb.PADDR), 32'h0F0);
    cyc;
    cyc;
    settle;
    chk("mr.rvalid0", 32'(rvalid), 32'b001);
    chk("mr.rdata", rdata, 32'h0BAD_F00D);
    cyc;
    settle;
    chk("mr.gnt_next", 32'(gnt), 32'b010);
    cyc;
    req[1] = 1'b0;
    cyc;
    cyc;
    settle;
    chk("mr.rvalid1", 32'(rvalid), 32'b010);
    cyc;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
